xadc_sample_packetizer: RTL and testbench



---
 rtl/xadc_packet_pkg.sv | 23 ++
 rtl/axis_sample_holder.sv | 54 +++++
 rtl/xadc_sample_packetizer.sv | 139 +++++++++++++
 tb/tb_xadc_sample_packetizer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_packet_pkg.sv
// Shared definitions for the XADC sample packetizer.
// Holds the FSM state type, the frame geometry and the checksum helper
// used when a voltage/current pair is loaded into the frame registers.
package xadc_packet_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } packetizer_state_t;

  localparam int         FRAME_LEN      = 7;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam logic [2:0] LAST_BYTE_IDX  = 3'(FRAME_LEN - 1);

  // XOR of the six bytes that precede the checksum in a frame
  function automatic logic [7:0] frameChecksum(input logic [7:0]  header,
                                               input logic [15:0] voltage,
                                               input logic [15:0] current,
                                               input logic [7:0]  seq);
    return header ^ voltage[15:8] ^ voltage[7:0] ^ current[15:8] ^ current[7:0] ^ seq;
  endfunction

endpackage

// File: rtl/axis_sample_holder.sv
// One-entry AXI-stream sample holding register.
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   tvalid_i/tready_o/tdata_i - AXI-stream sink for one sample channel
//   take_i         - frame loader consumed the held sample this cycle
//   full_o, data_o - holder occupancy and held sample
module axis_sample_holder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tvalid_i,
  output logic             tready_o,
  input  logic [WIDTH-1:0] tdata_i,
  input  logic             take_i,
  output logic             full_o,
  output logic [WIDTH-1:0] data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  // Never accept while reset is held, even though full_q is being cleared
  assign tready_o = rst && !full_q;
  assign accept   = tvalid_i && tready_o;
  assign full_o   = full_q;
  assign data_o   = data_q;

  // Take clears first, a same-cycle refill then sets, so a new sample is never lost
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (take_i) begin
      full_d = 1'b0;
    end
    if (accept) begin
      full_d = 1'b1;
      data_d = tdata_i;
    end
  end

  // Holder state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/xadc_sample_packetizer.sv
// Pairs one voltage sample with one current sample and serialises each pair
// as a 7-byte frame: header, V hi, V lo, I hi, I lo, seq, XOR checksum.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   voltage_channel_*             - 16-bit AXI-stream sink, voltage samples
//   current_monitor_channel_*     - 16-bit AXI-stream sink, current samples
//   packet_out_*                  - 8-bit AXI-stream source with tlast on byte 6
module xadc_sample_packetizer
  import xadc_packet_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE  = DEFAULT_HEADER,
  parameter int         SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    voltage_channel_tvalid_i,
  output logic                    voltage_channel_tready_o,
  input  logic [SAMPLE_WIDTH-1:0] voltage_channel_tdata_i,
  input  logic                    current_monitor_channel_tvalid_i,
  output logic                    current_monitor_channel_tready_o,
  input  logic [SAMPLE_WIDTH-1:0] current_monitor_channel_tdata_i,
  output logic                    packet_out_tvalid_o,
  input  logic                    packet_out_tready_i,
  output logic [7:0]              packet_out_tdata_o,
  output logic                    packet_out_tlast_o
);

  logic                    voltFull, currFull, take;
  logic [SAMPLE_WIDTH-1:0] voltHeld, currHeld;

  packetizer_state_t       state_q, state_d;
  logic [2:0]              byteIdx_q, byteIdx_d, nextIdx;
  logic [7:0]              seq_q, seq_d;
  logic [SAMPLE_WIDTH-1:0] voltage_q, voltage_d;
  logic [SAMPLE_WIDTH-1:0] current_q, current_d;
  logic [7:0]              checksum_q, checksum_d;
  logic [7:0]              tdata_q, tdata_d;
  logic                    tlast_q, tlast_d;

  axis_sample_holder #(.WIDTH(SAMPLE_WIDTH)) u_voltHolder (
    .clk      (clk),
    .rst      (rst),
    .tvalid_i (voltage_channel_tvalid_i),
    .tready_o (voltage_channel_tready_o),
    .tdata_i  (voltage_channel_tdata_i),
    .take_i   (take),
    .full_o   (voltFull),
    .data_o   (voltHeld)
  );

  axis_sample_holder #(.WIDTH(SAMPLE_WIDTH)) u_currHolder (
    .clk      (clk),
    .rst      (rst),
    .tvalid_i (current_monitor_channel_tvalid_i),
    .tready_o (current_monitor_channel_tready_o),
    .tdata_i  (current_monitor_channel_tdata_i),
    .take_i   (take),
    .full_o   (currFull),
    .data_o   (currHeld)
  );

  assign nextIdx             = byteIdx_q + 3'd1;
  assign packet_out_tvalid_o = (state_q == SEND);
  assign packet_out_tdata_o  = tdata_q;
  assign packet_out_tlast_o  = tlast_q;

  // Frame loader and byte sequencer; the output byte is registered one step
  // ahead so tdata/tlast are already stable when tvalid is seen
  always_comb begin
    state_d    = state_q;
    byteIdx_d  = byteIdx_q;
    seq_d      = seq_q;
    voltage_d  = voltage_q;
    current_d  = current_q;
    checksum_d = checksum_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    take       = 1'b0;
    case (state_q)
      IDLE: begin
        if (voltFull && currFull) begin
          take       = 1'b1;
          voltage_d  = voltHeld;
          current_d  = currHeld;
          checksum_d = frameChecksum(HEADER_BYTE, voltHeld, currHeld, seq_q);
          byteIdx_d  = 3'd0;
          tdata_d    = HEADER_BYTE;
          tlast_d    = 1'b0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (packet_out_tready_i) begin
          if (byteIdx_q == LAST_BYTE_IDX) begin
            seq_d   = seq_q + 8'd1;
            tlast_d = 1'b0;
            state_d = IDLE;
          end else begin
            byteIdx_d = nextIdx;
            tlast_d   = (nextIdx == LAST_BYTE_IDX);
            case (nextIdx)
              3'd1:    tdata_d = voltage_q[15:8];
              3'd2:    tdata_d = voltage_q[7:0];
              3'd3:    tdata_d = current_q[15:8];
              3'd4:    tdata_d = current_q[7:0];
              3'd5:    tdata_d = seq_q;
              default: tdata_d = checksum_q;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and frame registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      byteIdx_q  <= 3'd0;
      seq_q      <= 8'd0;
      voltage_q  <= '0;
      current_q  <= '0;
      checksum_q <= 8'd0;
      tdata_q    <= 8'd0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteIdx_q  <= byteIdx_d;
      seq_q      <= seq_d;
      voltage_q  <= voltage_d;
      current_q  <= current_d;
      checksum_q <= checksum_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
    end
  end

endmodule

// File: tb/tb_xadc_sample_packetizer.sv
// Self-checking bench for xadc_sample_packetizer: directed scenarios plus a
// randomized phase, all output bytes checked against a frame-level model.
module tb_xadc_sample_packetizer;

  localparam logic [7:0] HDR = 8'hA5;

  logic        clk, rst;
  logic        vValid, vReady, cValid, cReady;
  logic [15:0] vData, cData;
  logic        outValid, oReady, outLast;
  logic [7:0]  outData;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Reference model: accepted samples per channel, expected bytes {tlast,tdata}
  logic [15:0] vq[$];
  logic [15:0] cq[$];
  logic [8:0]  expQ[$];
  logic [7:0]  mSeq;
  int          framesSeen = 0;
  int          vAcc, cAcc, byteCnt;
  logic [7:0]  curFrame[7];
  logic [7:0]  lastFrame[7];
  logic        prevStall, prevLast;
  logic [7:0]  prevData;
  logic [8:0]  expByte;

  xadc_sample_packetizer #(.HEADER_BYTE(HDR), .SAMPLE_WIDTH(16)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .voltage_channel_tvalid_i         (vValid),
    .voltage_channel_tready_o         (vReady),
    .voltage_channel_tdata_i          (vData),
    .current_monitor_channel_tvalid_i (cValid),
    .current_monitor_channel_tready_o (cReady),
    .current_monitor_channel_tdata_i  (cData),
    .packet_out_tvalid_o              (outValid),
    .packet_out_tready_i              (oReady),
    .packet_out_tdata_o               (outData),
    .packet_out_tlast_o               (outLast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorsApplied++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest voltage and current sample and append the frame they form
  task automatic buildFrame();
    logic [15:0] v, c;
    logic [7:0]  b[7];
    v = vq.pop_front();
    c = cq.pop_front();
    b[0] = HDR; b[1] = v[15:8]; b[2] = v[7:0]; b[3] = c[15:8]; b[4] = c[7:0]; b[5] = mSeq;
    b[6] = 8'd0;
    for (int i = 0; i < 6; i++) b[6] = b[6] ^ b[i];
    for (int i = 0; i < 7; i++) expQ.push_back({1'(i == 6), b[i]});
    mSeq = mSeq + 8'd1;
  endtask

  // Scoreboard and output-protocol monitor, sampled mid-cycle
  initial begin
    mSeq = 8'd0; vAcc = 0; cAcc = 0; byteCnt = 0; prevStall = 1'b0;
    prevLast = 1'b0; prevData = 8'd0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        vq.delete(); cq.delete(); expQ.delete();
        mSeq = 8'd0; vAcc = 0; cAcc = 0; byteCnt = 0; prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("stallValid", 32'(outValid), 32'd1);
          checkOutput("stallHold", 32'({outLast, outData}), 32'({prevLast, prevData}));
        end
        if (vValid && vReady) begin vq.push_back(vData); vAcc++; end
        if (cValid && cReady) begin cq.push_back(cData); cAcc++; end
        if (outValid && oReady) begin
          if (expQ.size() == 0) begin
            if (vq.size() > 0 && cq.size() > 0) buildFrame();
            else checkOutput("spuriousValid", 32'(outValid), 32'd0);
          end
          if (expQ.size() > 0) begin
            expByte = expQ.pop_front();
            checkOutput("frameByte", 32'({outLast, outData}), 32'(expByte));
          end
          if (byteCnt < 7) curFrame[byteCnt] = outData;
          byteCnt++;
          if (outLast) begin
            lastFrame  = curFrame;
            framesSeen = framesSeen + 1;
            byteCnt    = 0;
          end
        end
        prevStall = outValid && !oReady;
        prevData  = outData;
        prevLast  = outLast;
      end
    end
  end

  task automatic doReset();
    stepCycle();
    rst = 1'b0; vValid = 1'b0; cValid = 1'b0;
    repeat (2) stepCycle();
    rst = 1'b1;
  endtask

  // Offer one sample on one channel and hold it until accepted (bounded)
  task automatic applyStimulus(input bit isCurrent, input logic [15:0] data);
    bit accepted = 1'b0;
    stepCycle();
    vValid = 1'b0; cValid = 1'b0;
    if (isCurrent) begin cValid = 1'b1; cData = data; end
    else begin vValid = 1'b1; vData = data; end
    for (int k = 0; k < 100 && !accepted; k++) begin
      @(negedge clk);
      accepted = isCurrent ? cReady : vReady;
      if (!accepted) stepCycle();
    end
    checkOutput(isCurrent ? "cAccept" : "vAccept", 32'(accepted), 32'd1);
    #1;
  endtask

  task automatic waitFrames(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && framesSeen < target; k++) begin
      @(negedge clk);
      #1;
    end
    checkOutput(tag, 32'(framesSeen), 32'(target));
  endtask

  task automatic randomPhase(input int cycles);
    bit vHs = 1'b0, cHs = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      stepCycle();
      if (vHs) vValid = 1'b0;
      if (cHs) cValid = 1'b0;
      if (!vValid) begin vValid = 1'($urandom_range(0, 1)); vData = 16'($urandom); end
      if (!cValid) begin cValid = 1'($urandom_range(0, 1)); cData = 16'($urandom); end
      oReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      vHs = vValid && vReady;
      cHs = cValid && cReady;
    end
    stepCycle();
    if (vHs) vValid = 1'b0;
    if (cHs) cValid = 1'b0;
    oReady = 1'b1;
    for (int k = 0; k < 100 && (vValid || cValid); k++) begin
      @(negedge clk);
      vHs = vValid && vReady;
      cHs = cValid && cReady;
      stepCycle();
      if (vHs) vValid = 1'b0;
      if (cHs) cValid = 1'b0;
    end
    for (int k = 0; k < 20 && vAcc != cAcc; k++) begin
      if (vAcc < cAcc) applyStimulus(1'b0, 16'($urandom));
      else             applyStimulus(1'b1, 16'($urandom));
    end
    stepCycle();
    vValid = 1'b0; cValid = 1'b0;
    for (int k = 0; k < 300 && (vq.size() + cq.size() + expQ.size()) != 0; k++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("randDrain", 32'(vq.size() + cq.size() + expQ.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t1[7];
    int         start, cSent;
    bit         vDone;

    rst = 1'b0; vValid = 1'b0; cValid = 1'b0; oReady = 1'b0;
    vData = 16'd0; cData = 16'd0;

    // Reset values
    repeat (3) stepCycle();
    @(negedge clk);
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstData", 32'(outData), 32'd0);
    checkOutput("rstLast", 32'(outLast), 32'd0);
    checkOutput("rstVReady", 32'(vReady), 32'd0);
    checkOutput("rstCReady", 32'(cReady), 32'd0);
    stepCycle();
    rst = 1'b1; oReady = 1'b1;

    // Basic frame with cycle-exact timing
    $display("[TB] basic frame");
    t1[0] = HDR; t1[1] = 8'h12; t1[2] = 8'h34; t1[3] = 8'hAB; t1[4] = 8'hCD; t1[5] = 8'h00;
    t1[6] = HDR ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD ^ 8'h00;
    applyStimulus(1'b0, 16'h1234);
    applyStimulus(1'b1, 16'hABCD);
    stepCycle();
    cValid = 1'b0;
    @(negedge clk);
    checkOutput("preHeaderValid", 32'(outValid), 32'd0);
    for (int i = 0; i < 7; i++) begin
      stepCycle();
      @(negedge clk);
      checkOutput("basicValid", 32'(outValid), 32'd1);
      checkOutput("basicByte", 32'(outData), 32'(t1[i]));
      checkOutput("basicLast", 32'(outLast), 32'(i == 6));
    end
    stepCycle();
    @(negedge clk);
    checkOutput("postFrameValid", 32'(outValid), 32'd0);

    // Reversed arrival, sequence wrap over 257 frames
    $display("[TB] sequence wrap");
    doReset();
    oReady = 1'b1;
    for (int f = 0; f < 257; f++) begin
      start = framesSeen;
      applyStimulus(1'b1, 16'($urandom));
      applyStimulus(1'b0, 16'($urandom));
      stepCycle();
      vValid = 1'b0;
      waitFrames("wrapFrame", start + 1, 30);
      checkOutput("wrapSeq", 32'(lastFrame[5]), 32'(f % 256));
    end

    // Output stall at byte 3 with a new pair accepted during the stall
    $display("[TB] output stall");
    doReset();
    oReady = 1'b1;
    start = framesSeen;
    stepCycle();
    vValid = 1'b1; vData = 16'h5A01; cValid = 1'b1; cData = 16'hC3D4;
    @(negedge clk);
    checkOutput("stallInV", 32'(vReady), 32'd1);
    checkOutput("stallInC", 32'(cReady), 32'd1);
    stepCycle();
    vValid = 1'b0; cValid = 1'b0;
    @(negedge clk);
    stepCycle();
    @(negedge clk);
    checkOutput("stallHdr", 32'({outValid, outData}), 32'({1'b1, HDR}));
    repeat (2) begin stepCycle(); @(negedge clk); end
    stepCycle();
    oReady = 1'b0; vValid = 1'b1; vData = 16'h0F0E; cValid = 1'b1; cData = 16'h7766;
    @(negedge clk);
    checkOutput("stallNewV", 32'(vReady), 32'd1);
    checkOutput("stallNewC", 32'(cReady), 32'd1);
    checkOutput("stallByte3", 32'({outValid, outData}), 32'({1'b1, 8'hC3}));
    for (int s = 1; s < 5; s++) begin
      stepCycle();
      vValid = 1'b0; cValid = 1'b0;
      @(negedge clk);
      checkOutput("stallByte3", 32'({outValid, outData}), 32'({1'b1, 8'hC3}));
    end
    stepCycle();
    oReady = 1'b1;
    @(negedge clk);
    repeat (3) begin stepCycle(); @(negedge clk); end
    checkOutput("stallTlast", 32'({outValid, outLast}), 32'b11);
    stepCycle();
    @(negedge clk);
    checkOutput("gapValid", 32'(outValid), 32'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("nextHdr", 32'({outValid, outData}), 32'({1'b1, HDR}));
    waitFrames("stallFrames", start + 2, 20);

    // Backpressure reaching the input holders
    $display("[TB] input backpressure");
    doReset();
    oReady = 1'b0;
    start = framesSeen;
    stepCycle();
    vValid = 1'b1; vData = 16'h1111; cValid = 1'b1; cData = 16'h2222;
    @(negedge clk);
    checkOutput("bpFirst", 32'({vReady, cReady}), 32'b11);
    stepCycle();
    cValid = 1'b0; vData = 16'h3333;
    @(negedge clk);
    checkOutput("bpLoadCycle", 32'(vReady), 32'd0);
    stepCycle();
    @(negedge clk);
    checkOutput("bpSecond", 32'(vReady), 32'd1);
    stepCycle();
    vData = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) stepCycle();
      @(negedge clk);
      checkOutput("bpThirdBlocked", 32'(vReady), 32'd0);
    end
    stepCycle();
    oReady = 1'b1; cValid = 1'b1; cData = 16'h4444;
    cSent = 0; vDone = 1'b0;
    for (int k = 0; k < 100 && !(vDone && cSent == 2); k++) begin
      @(negedge clk);
      if (vValid && vReady) vDone = 1'b1;
      if (cValid && cReady) cSent++;
      stepCycle();
      if (vDone) vValid = 1'b0;
      if (cSent == 1) cData = 16'h6666;
      if (cSent == 2) cValid = 1'b0;
    end
    checkOutput("bpThirdTaken", 32'({vDone, 8'(cSent)}), 32'({1'b1, 8'd2}));
    waitFrames("bpFrames", start + 3, 60);

    // Reset in the middle of a frame
    $display("[TB] reset mid-frame");
    doReset();
    oReady = 1'b1;
    stepCycle();
    vValid = 1'b1; vData = 16'hBEEF; cValid = 1'b1; cData = 16'hCAFE;
    @(negedge clk);
    stepCycle();
    vValid = 1'b0; cValid = 1'b0;
    @(negedge clk);
    repeat (3) begin stepCycle(); @(negedge clk); end
    stepCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midRstReady", 32'({vReady, cReady}), 32'b00);
    stepCycle();
    @(negedge clk);
    checkOutput("midRstValid", 32'(outValid), 32'd0);
    stepCycle();
    rst = 1'b1;
    start = framesSeen;
    applyStimulus(1'b0, 16'h0102);
    applyStimulus(1'b1, 16'h0304);
    stepCycle();
    cValid = 1'b0;
    waitFrames("midRstFrame", start + 1, 30);
    checkOutput("midRstSeq", 32'(lastFrame[5]), 32'd0);

    // Single-channel starvation
    $display("[TB] starvation");
    doReset();
    oReady = 1'b1;
    start = framesSeen;
    applyStimulus(1'b0, 16'h0AAA);
    stepCycle();
    vData = 16'h0BBB;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("starveVReady", 32'(vReady), 32'd0);
      checkOutput("starveOut", 32'(outValid), 32'd0);
      stepCycle();
    end
    cValid = 1'b1; cData = 16'h0CCC;
    cSent = 0; vDone = 1'b0;
    for (int k = 0; k < 100 && !(vDone && cSent == 1); k++) begin
      @(negedge clk);
      if (vValid && vReady) vDone = 1'b1;
      if (cValid && cReady) cSent++;
      stepCycle();
      if (vDone) vValid = 1'b0;
      if (cSent == 1) cValid = 1'b0;
    end
    checkOutput("starveRelease", 32'({vDone, 8'(cSent)}), 32'({1'b1, 8'd1}));
    applyStimulus(1'b1, 16'h0DDD);
    stepCycle();
    cValid = 1'b0;
    waitFrames("starveFrames", start + 2, 40);

    // Randomized traffic against the frame model
    $display("[TB] random traffic");
    doReset();
    randomPhase(600);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
